// File: rtl/iir_sos_inverse_serial.sv
// Inverse cascaded-biquad IIR (equalizer) on one shared multiplier, sections run S-1..0.
// Define IIR_INV_SAT_EN to saturate accumulator adds and the section scale instead of wrapping.
//
// state | meaning
// IDLE  | in_ready high, waiting for an input sample
// MAC   | four multiply-accumulates of section k: +a1*u1, +a2*u2, -b1*w1, -b2*w2
// SCALE | acc <= GINV_k*acc, shift section k history, move to next section or OUT
// OUT   | out_valid high with out_data held until out_ready
module iir_sos_inverse_serial #(
  parameter int width_H = 15,
  parameter int width_W = 10,
  parameter int N = 8,
  parameter logic [N-1:0][width_H+width_W-1:0] const_num_A = '0,
  parameter logic [N-1:0][width_H+width_W-1:0] const_num_B = '0,
  parameter logic [N/2-1:0][width_H+width_W-1:0] const_num_GINV =
    {(N/2){{{(width_H-1){1'b0}}, 1'b1, {width_W{1'b0}}}}}
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic signed [width_H+width_W-1:0] in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic signed [width_H+width_W-1:0] out_data,
  input  logic                              out_ready
);

  localparam int W  = width_H + width_W;
  localparam int S  = N / 2;
  localparam int KW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;

  state_t              state;
  logic [KW-1:0]       k;
  logic [1:0]          step;
  logic signed [W-1:0] acc;
  logic signed [W-1:0] u_cur;
  logic signed [W-1:0] u1 [S];
  logic signed [W-1:0] u2 [S];
  logic signed [W-1:0] w1 [S];
  logic signed [W-1:0] w2 [S];

  logic signed [W-1:0]   mul_a, mul_b;
  logic signed [2*W-1:0] product, prod_sh;
  logic signed [W+1:0]   acc_x, prod_x, sum;
  logic signed [W-1:0]   acc_next, scaled;

  // Operand select: coefficient and history word of the current section and step.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int s = 0; s < S; s++) begin
      if (k == KW'(s)) begin
        if (state == SCALE) begin
          mul_a = const_num_GINV[s];
          mul_b = acc;
        end else begin
          case (step)
            2'd0: begin mul_a = const_num_A[2*s];   mul_b = u1[s]; end
            2'd1: begin mul_a = const_num_A[2*s+1]; mul_b = u2[s]; end
            2'd2: begin mul_a = const_num_B[2*s];   mul_b = w1[s]; end
            default: begin mul_a = const_num_B[2*s+1]; mul_b = w2[s]; end
          endcase
        end
      end
    end
  end

  assign product = mul_a * mul_b;
  assign prod_sh = product >>> width_W;
  assign acc_x   = {{2{acc[W-1]}}, acc};
  assign prod_x  = {{2{prod_sh[W-1]}}, prod_sh[W-1:0]};
  // b terms are poles of the inverse, so their truncated products are subtracted.
  assign sum     = step[1] ? (acc_x - prod_x) : (acc_x + prod_x);

`ifdef IIR_INV_SAT_EN
  localparam logic signed [W+1:0]   SUM_MAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0]   SUM_MIN = {3'b111, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] PRD_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] PRD_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  always_comb begin
    if (sum > SUM_MAX)      acc_next = {1'b0, {(W-1){1'b1}}};
    else if (sum < SUM_MIN) acc_next = {1'b1, {(W-1){1'b0}}};
    else                    acc_next = sum[W-1:0];
    if (prod_sh > PRD_MAX)      scaled = {1'b0, {(W-1){1'b1}}};
    else if (prod_sh < PRD_MIN) scaled = {1'b1, {(W-1){1'b0}}};
    else                        scaled = prod_sh[W-1:0];
  end
`else
  assign acc_next = sum[W-1:0];
  assign scaled   = prod_sh[W-1:0];
`endif

  logic unused_bits;
  assign unused_bits = ^{product[width_W-1:0], prod_sh[2*W-1:W], sum[W+1:W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      u_cur     <= '0;
      k         <= '0;
      step      <= '0;
      for (int s = 0; s < S; s++) begin
        u1[s] <= '0;
        u2[s] <= '0;
        w1[s] <= '0;
        w2[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            acc      <= in_data;
            u_cur    <= in_data;
            k        <= KW'(S-1);
            step     <= 2'd0;
            in_ready <= 1'b0;
            state    <= MAC;
          end else begin
            in_ready <= 1'b1;
          end
        end
        MAC: begin
          acc  <= acc_next;
          step <= step + 2'd1;
          if (step == 2'd3) state <= SCALE;
        end
        SCALE: begin
          acc   <= scaled;
          u_cur <= scaled;
          for (int s = 0; s < S; s++) begin
            if (k == KW'(s)) begin
              u2[s] <= u1[s];
              u1[s] <= u_cur;
              w2[s] <= w1[s];
              w1[s] <= acc;
            end
          end
          if (k == '0) begin
            out_valid <= 1'b1;
            out_data  <= scaled;
            state     <= OUT;
          end else begin
            k     <= k - KW'(1);
            state <= MAC;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_sos_inverse_serial.sv
// Bench for iir_sos_inverse_serial: several instances (identity, pole, zero, overflow, random
// coefficients) checked against an arithmetic model of the section equations.
module tb_iir_sos_inverse_serial;
  localparam int W = 25;
  localparam int FRAC = 10;
  localparam int NI = 6;
`ifdef IIR_INV_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint MOD  = longint'(1) << W;
  localparam longint MAXV = MOD / 2 - 1;
  localparam longint MINV = -(MOD / 2);

  localparam logic [1:0][W-1:0] P_B = {W'(0), W'(-512)};
  localparam logic [1:0][W-1:0] Z_A = {W'(0), W'(2048)};
  localparam logic [1:0][W-1:0] O_A = {W'(0), W'(1024)};
  localparam logic [7:0][W-1:0] R_A = {W'(40), W'(80), W'(-256), W'(512),
                                       W'(100), W'(-150), W'(-200), W'(300)};
  localparam logic [7:0][W-1:0] R_B = {W'(30), W'(-90), W'(128), W'(250),
                                       W'(-50), W'(100), W'(200), W'(-400)};
  localparam logic [3:0][W-1:0] R_G = {W'(700), W'(1024), W'(900), W'(1100)};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic                in_valid  [NI];
  logic signed [W-1:0] in_data   [NI];
  logic                in_ready  [NI];
  logic                out_valid [NI];
  logic signed [W-1:0] out_data  [NI];
  logic                out_ready [NI];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iir_sos_inverse_serial #(.N(8)) u_id8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]));
  iir_sos_inverse_serial #(.N(2)) u_id2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]));
  iir_sos_inverse_serial #(.N(2), .const_num_B(P_B)) u_pole (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_data(in_data[2]), .in_ready(in_ready[2]),
    .out_valid(out_valid[2]), .out_data(out_data[2]), .out_ready(out_ready[2]));
  iir_sos_inverse_serial #(.N(2), .const_num_A(Z_A)) u_zero (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_data(in_data[3]), .in_ready(in_ready[3]),
    .out_valid(out_valid[3]), .out_data(out_data[3]), .out_ready(out_ready[3]));
  iir_sos_inverse_serial #(.N(2), .const_num_A(O_A)) u_ovf (
    .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_data(in_data[4]), .in_ready(in_ready[4]),
    .out_valid(out_valid[4]), .out_data(out_data[4]), .out_ready(out_ready[4]));
  iir_sos_inverse_serial #(.N(8), .const_num_A(R_A), .const_num_B(R_B), .const_num_GINV(R_G)) u_rnd (
    .clk(clk), .rst(rst), .in_valid(in_valid[5]), .in_data(in_data[5]), .in_ready(in_ready[5]),
    .out_valid(out_valid[5]), .out_data(out_data[5]), .out_ready(out_ready[5]));

  // Reference model: per-instance coefficients and section histories as plain integers.
  longint ca [NI][8];
  longint cb [NI][8];
  longint cg [NI][4];
  int     nsec [NI];
  longint mu1 [NI][4];
  longint mu2 [NI][4];
  longint mw1 [NI][4];
  longint mw2 [NI][4];

  function automatic longint wrapw(longint v);
    longint m = v & (MOD - 1);
    if (m > MAXV) m = m - MOD;
    return m;
  endfunction

  function automatic longint clampw(longint v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic longint addq(longint a, longint b);
    return SAT ? clampw(a + b) : wrapw(a + b);
  endfunction

  function automatic longint mulq(longint c, longint d);
    return wrapw((c * d) >>> FRAC);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NI; i++)
      for (int s = 0; s < 4; s++) begin
        mu1[i][s] = 0; mu2[i][s] = 0; mw1[i][s] = 0; mw2[i][s] = 0;
      end
  endfunction

  function automatic longint model_step(int i, longint x);
    longint u = x;
    longint w, v;
    for (int s = nsec[i] - 1; s >= 0; s--) begin
      w = addq(u, mulq(ca[i][2*s], mu1[i][s]));
      w = addq(w, mulq(ca[i][2*s+1], mu2[i][s]));
      w = addq(w, -mulq(cb[i][2*s], mw1[i][s]));
      w = addq(w, -mulq(cb[i][2*s+1], mw2[i][s]));
      v = SAT ? clampw((cg[i][s] * w) >>> FRAC) : wrapw((cg[i][s] * w) >>> FRAC);
      mu2[i][s] = mu1[i][s]; mu1[i][s] = u;
      mw2[i][s] = mw1[i][s]; mw1[i][s] = w;
      u = v;
    end
    return u;
  endfunction

  function automatic void model_init();
    for (int i = 0; i < NI; i++) begin
      nsec[i] = (i == 0 || i == 5) ? 4 : 1;
      for (int j = 0; j < 8; j++) begin ca[i][j] = 0; cb[i][j] = 0; end
      for (int s = 0; s < 4; s++) cg[i][s] = 1024;
    end
    for (int j = 0; j < 8; j++) begin
      ca[5][j] = longint'($signed(R_A[j]));
      cb[5][j] = longint'($signed(R_B[j]));
    end
    for (int s = 0; s < 4; s++) cg[5][s] = longint'($signed(R_G[s]));
    cb[2][0] = -512;
    ca[3][0] = 2048;
    ca[4][0] = 1024;
    model_clear();
  endfunction

  function automatic longint rnd();
    return longint'(int'($urandom_range(2097152))) - 1048576;
  endfunction

  // One sample in, one sample out; called and returns on a falling edge.
  task automatic xfer(input int i, input longint x, output longint y, output int lat, output bit ok);
    int t = 0;
    ok = 1'b0; lat = 0; y = 0;
    out_ready[i] = 1'b1; in_valid[i] = 1'b1; in_data[i] = W'(x);
    while (!in_ready[i] && t < 100) begin @(negedge clk); t++; end
    if (!in_ready[i]) begin in_valid[i] = 1'b0; return; end
    @(negedge clk);
    in_valid[i] = 1'b0;
    lat = 1;
    while (!out_valid[i] && lat < 100) begin @(negedge clk); lat++; end
    if (out_valid[i]) begin
      ok = 1'b1;
      y = out_data[i];
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_chk++;
      if (in_ready[i] !== 1'b0 || out_valid[i] !== 1'b0 || out_data[i] !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: in_ready=%b out_valid=%b out_data=%0d, want 0 0 0",
                 i, in_ready[i], out_valid[i], out_data[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      n_chk++;
      if (in_ready[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: in_ready=%b want 1", i, in_ready[i]);
      end
    end
  endtask

  task automatic test_identity();
    longint xs [3] = '{500, -3, 0};
    longint y; int lat; bit ok;
    for (int j = 0; j < 3; j++) begin
      xfer(1, xs[j], y, lat, ok);
      n_chk++;
      if (!ok || y != xs[j] || lat != 6) begin
        n_fail++;
        $display("FAIL identity_s1[%0d]: got %0d lat %0d ok %0b, want %0d lat 6", j, y, lat, ok, xs[j]);
      end
      xfer(0, xs[j], y, lat, ok);
      n_chk++;
      if (!ok || y != xs[j] || lat != 21) begin
        n_fail++;
        $display("FAIL identity_s4[%0d]: got %0d lat %0d ok %0b, want %0d lat 21", j, y, lat, ok, xs[j]);
      end
    end
  endtask

  task automatic test_pole();
    longint xs [4] = '{1024, 0, 0, 0};
    longint ex [4] = '{1024, 512, 256, 128};
    longint y; int lat; bit ok;
    for (int j = 0; j < 4; j++) begin
      xfer(2, xs[j], y, lat, ok);
      void'(model_step(2, xs[j]));
      n_chk++;
      if (!ok || y != ex[j]) begin
        n_fail++;
        $display("FAIL pole[%0d]: got %0d ok %0b, want %0d", j, y, ok, ex[j]);
      end
    end
  endtask

  task automatic test_zero();
    longint xs [3] = '{1024, 0, 0};
    longint ex [3] = '{1024, 2048, 0};
    longint y; int lat; bit ok;
    for (int j = 0; j < 3; j++) begin
      xfer(3, xs[j], y, lat, ok);
      void'(model_step(3, xs[j]));
      n_chk++;
      if (!ok || y != ex[j]) begin
        n_fail++;
        $display("FAIL zero[%0d]: got %0d ok %0b, want %0d", j, y, ok, ex[j]);
      end
    end
  endtask

  task automatic test_overflow();
    longint ex [2];
    longint y; int lat; bit ok;
    ex[0] = 16777215;
`ifdef IIR_INV_SAT_EN
    ex[1] = 16777215;
`else
    ex[1] = -2;
`endif
    for (int j = 0; j < 2; j++) begin
      xfer(4, 16777215, y, lat, ok);
      n_chk++;
      if (!ok || y != ex[j]) begin
        n_fail++;
        $display("FAIL overflow[%0d]: got %0d ok %0b, want %0d", j, y, ok, ex[j]);
      end
    end
  endtask

  task automatic test_random();
    longint x, y, e; int lat; bit ok;
    for (int j = 0; j < 30; j++) begin
      x = rnd();
      e = model_step(5, x);
      xfer(5, x, y, lat, ok);
      n_chk++;
      if (!ok || y != e || lat != 21) begin
        n_fail++;
        $display("FAIL random[%0d]: in %0d got %0d lat %0d ok %0b, want %0d lat 21", j, x, y, lat, ok, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int n_out = 0;
    int acc_cyc [$];
    longint expq [$];
    longint x, e;
    bit pend = 1'b0;
    out_ready[5] = 1'b1;
    x = rnd();
    in_data[5] = W'(x);
    in_valid[5] = 1'b1;
    while (n_out < 4 && cyc < 300) begin
      if (out_valid[5]) begin
        e = (expq.size() > 0) ? expq.pop_front() : 0;
        n_chk++;
        if (out_data[5] != e) begin
          n_fail++;
          $display("FAIL b2b_data[%0d]: got %0d want %0d", n_out, out_data[5], e);
        end
        n_out++;
      end
      if (in_ready[5] && in_valid[5]) begin
        acc_cyc.push_back(cyc);
        expq.push_back(model_step(5, x));
        x = rnd();
        pend = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (pend) begin in_data[5] = W'(x); pend = 1'b0; end
    end
    in_valid[5] = 1'b0;
    n_chk++;
    if (n_out < 4) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d outputs want 4", n_out);
    end
    for (int j = 1; j < acc_cyc.size(); j++) begin
      n_chk++;
      if (acc_cyc[j] - acc_cyc[j-1] != 22) begin
        n_fail++;
        $display("FAIL b2b_period[%0d]: got %0d cycles want 22", j, acc_cyc[j] - acc_cyc[j-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    longint x1, x2, e1, e2, held;
    int t = 0;
    x1 = rnd(); e1 = model_step(5, x1);
    out_ready[5] = 1'b0; in_valid[5] = 1'b1; in_data[5] = W'(x1);
    while (!in_ready[5] && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    in_valid[5] = 1'b0;
    t = 0;
    while (!out_valid[5] && t < 100) begin @(negedge clk); t++; end
    held = out_data[5];
    n_chk++;
    if (out_valid[5] !== 1'b1 || held != e1) begin
      n_fail++;
      $display("FAIL bp_first: got %0d valid %b want %0d", held, out_valid[5], e1);
    end
    x2 = rnd();
    in_valid[5] = 1'b1; in_data[5] = W'(x2);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      n_chk++;
      if (out_valid[5] !== 1'b1 || out_data[5] != e1 || in_ready[5] !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid %b data %0d in_ready %b, want 1 %0d 0",
                 j, out_valid[5], out_data[5], in_ready[5], e1);
      end
    end
    out_ready[5] = 1'b1;
    @(negedge clk);
    n_chk++;
    if (out_valid[5] !== 1'b0 || in_ready[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: valid %b in_ready %b, want 0 1", out_valid[5], in_ready[5]);
    end
    @(negedge clk);
    in_valid[5] = 1'b0;
    e2 = model_step(5, x2);
    t = 0;
    while (!out_valid[5] && t < 100) begin @(negedge clk); t++; end
    n_chk++;
    if (out_valid[5] !== 1'b1 || out_data[5] != e2) begin
      n_fail++;
      $display("FAIL bp_second: got %0d valid %b want %0d", out_data[5], out_valid[5], e2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    longint x, y, e; int lat; bit ok;
    int seen = 0;
    int t = 0;
    x = rnd();
    out_ready[5] = 1'b1; in_valid[5] = 1'b1; in_data[5] = W'(x);
    while (!in_ready[5] && t < 100) begin @(negedge clk); t++; end
    @(negedge clk);
    in_valid[5] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (out_valid[5]) seen++;
    end
    n_chk++;
    if (seen != 0 || in_ready[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_abort: %0d output cycles, in_ready %b, want 0 and 1", seen, in_ready[5]);
    end
    x = rnd();
    e = model_step(5, x);
    xfer(5, x, y, lat, ok);
    n_chk++;
    if (!ok || y != e) begin
      n_fail++;
      $display("FAIL rst_mid_next: got %0d ok %0b want %0d", y, ok, e);
    end
    x = rnd();
    e = model_step(5, x);
    xfer(5, x, y, lat, ok);
    n_chk++;
    if (!ok || y != e) begin
      n_fail++;
      $display("FAIL rst_mid_next2: got %0d ok %0b want %0d", y, ok, e);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1;
    end
    model_init();
    test_reset();
    test_identity();
    test_pole();
    test_zero();
    test_overflow();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
